// File: rtl/writeback_unit.sv
// writeback_unit: final pipeline stage of the GPU core.
//
// Collects completed scalar/vector results from the memory (LDW) and ALU paths, orders them
// (memory result is older than a same-cycle ALU result), and retires at most one register-file
// write per cycle through a registered write port. Results that cannot retire immediately are
// held in a small in-order circular queue.
//
// Optional feature: define WB_COND_CODE_EN to add the N/Z/P condition-code register and the
// O_CondCode port. Without it the port and register are absent.
//
// Ports:
//   I_CLOCK, I_RESET                  clock, synchronous active-high reset
//   I_Mem*/O_MemReady                 memory-path result handshake
//   I_Alu*/O_AluReady                 ALU-path result handshake
//   O_WriteBackEnable/Data            scalar register write
//   O_VWriteBackEnable/Data           vector register write
//   O_WriteBackRegIdx                 destination index shared by both writes
//   O_CondCode                        N/Z/P of the last scalar write (WB_COND_CODE_EN only)
//   O_Empty                           nothing queued and nothing on the write port

module writeback_unit #(
  parameter int unsigned REG_WIDTH  = 16,
  parameter int unsigned VREG_WIDTH = 64,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  I_CLOCK,
  input  logic                  I_RESET,

  input  logic                  I_MemValid,
  input  logic                  I_MemVector,
  input  logic [5:0]            I_MemRegIdx,
  input  logic [VREG_WIDTH-1:0] I_MemData,
  output logic                  O_MemReady,

  input  logic                  I_AluValid,
  input  logic                  I_AluVector,
  input  logic [5:0]            I_AluRegIdx,
  input  logic [VREG_WIDTH-1:0] I_AluData,
  output logic                  O_AluReady,

  output logic                  O_WriteBackEnable,
  output logic                  O_VWriteBackEnable,
  output logic [5:0]            O_WriteBackRegIdx,
  output logic [REG_WIDTH-1:0]  O_WriteBackData,
  output logic [VREG_WIDTH-1:0] O_VWriteBackData,
  output logic                  O_Empty
`ifdef WB_COND_CODE_EN
  ,
  output logic [2:0]            O_CondCode
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic                  vector;
    logic [5:0]            idx;
    logic [VREG_WIDTH-1:0] data;
  } entry_t;

  entry_t          queue_q [DEPTH];
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [PtrW-1:0] tail_p1;
  logic [CntW-1:0] count_q, count_d;

  entry_t mem_ent, alu_ent;
  logic   mem_acc, alu_acc;
  logic   out_valid;
  entry_t out_ent;
  logic   pop;
  logic   push0_en, push1_en;
  entry_t push0_ent, push1_ent;

  // Ready depends on registered occupancy only, so a same-cycle pop never frees a slot early.
  // The ALU path keeps one slot in reserve so both paths can be taken in one cycle.
  assign O_MemReady = (count_q < CntW'(DEPTH));
  assign O_AluReady = (count_q < CntW'(DEPTH - 1));

  assign mem_ent = '{vector: I_MemVector, idx: I_MemRegIdx, data: I_MemData};
  assign alu_ent = '{vector: I_AluVector, idx: I_AluRegIdx, data: I_AluData};
  assign mem_acc = I_MemValid & O_MemReady;
  assign alu_acc = I_AluValid & O_AluReady;

  assign tail_p1 = tail_q + 1'b1;

  // Oldest item goes to the write port: queue head, then memory arrival, then ALU arrival.
  // Anything not retired is appended in the same order.
  always_comb begin
    out_valid = 1'b0;
    out_ent   = '0;
    pop       = 1'b0;
    push0_en  = 1'b0;
    push0_ent = '0;
    push1_en  = 1'b0;
    push1_ent = '0;
    if (count_q != '0) begin
      out_valid = 1'b1;
      out_ent   = queue_q[head_q];
      pop       = 1'b1;
      if (mem_acc) begin
        push0_en  = 1'b1;
        push0_ent = mem_ent;
        if (alu_acc) begin
          push1_en  = 1'b1;
          push1_ent = alu_ent;
        end
      end else if (alu_acc) begin
        push0_en  = 1'b1;
        push0_ent = alu_ent;
      end
    end else if (mem_acc) begin
      out_valid = 1'b1;
      out_ent   = mem_ent;
      if (alu_acc) begin
        push0_en  = 1'b1;
        push0_ent = alu_ent;
      end
    end else if (alu_acc) begin
      out_valid = 1'b1;
      out_ent   = alu_ent;
    end
  end

  always_comb begin
    count_d = count_q + CntW'(push0_en) + CntW'(push1_en) - CntW'(pop);
    head_d  = head_q + PtrW'(pop);
    tail_d  = tail_q + PtrW'(push0_en) + PtrW'(push1_en);
  end

  // Storage needs no reset; occupancy is tracked by count/head/tail.
  always_ff @(posedge I_CLOCK) begin
    if (push0_en) queue_q[tail_q] <= push0_ent;
    if (push1_en) queue_q[tail_p1] <= push1_ent;
  end

  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      count_q            <= '0;
      head_q             <= '0;
      tail_q             <= '0;
      O_WriteBackEnable  <= 1'b0;
      O_VWriteBackEnable <= 1'b0;
      O_WriteBackRegIdx  <= '0;
      O_WriteBackData    <= '0;
      O_VWriteBackData   <= '0;
    end else begin
      count_q            <= count_d;
      head_q             <= head_d;
      tail_q             <= tail_d;
      O_WriteBackEnable  <= out_valid & ~out_ent.vector;
      O_VWriteBackEnable <= out_valid & out_ent.vector;
      if (out_valid) O_WriteBackRegIdx <= out_ent.idx;
      // The data output of the write kind not issued holds its value.
      if (out_valid && !out_ent.vector) O_WriteBackData <= out_ent.data[REG_WIDTH-1:0];
      if (out_valid && out_ent.vector) O_VWriteBackData <= out_ent.data;
    end
  end

  assign O_Empty = (count_q == '0) & ~O_WriteBackEnable & ~O_VWriteBackEnable;

`ifdef WB_COND_CODE_EN
  logic [2:0] cc_next;

  always_comb begin
    if (out_ent.data[REG_WIDTH-1]) begin
      cc_next = 3'b100;
    end else if (out_ent.data[REG_WIDTH-1:0] == '0) begin
      cc_next = 3'b010;
    end else begin
      cc_next = 3'b001;
    end
  end

  // Loads alongside the scalar write so the code is valid in the cycle the write appears.
  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      O_CondCode <= 3'b000;
    end else if (out_valid && !out_ent.vector) begin
      O_CondCode <= cc_next;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;

  localparam int unsigned REG_WIDTH  = 16;
  localparam int unsigned VREG_WIDTH = 64;
  localparam int unsigned DEPTH      = 4;

  logic                  I_CLOCK;
  logic                  I_RESET;
  logic                  I_MemValid;
  logic                  I_MemVector;
  logic [5:0]            I_MemRegIdx;
  logic [VREG_WIDTH-1:0] I_MemData;
  logic                  O_MemReady;
  logic                  I_AluValid;
  logic                  I_AluVector;
  logic [5:0]            I_AluRegIdx;
  logic [VREG_WIDTH-1:0] I_AluData;
  logic                  O_AluReady;
  logic                  O_WriteBackEnable;
  logic                  O_VWriteBackEnable;
  logic [5:0]            O_WriteBackRegIdx;
  logic [REG_WIDTH-1:0]  O_WriteBackData;
  logic [VREG_WIDTH-1:0] O_VWriteBackData;
  logic                  O_Empty;
`ifdef WB_COND_CODE_EN
  logic [2:0]            O_CondCode;
`endif

  int errors = 0;
  int checks = 0;

  writeback_unit #(
    .REG_WIDTH (REG_WIDTH),
    .VREG_WIDTH(VREG_WIDTH),
    .DEPTH     (DEPTH)
  ) dut (
    .I_CLOCK           (I_CLOCK),
    .I_RESET           (I_RESET),
    .I_MemValid        (I_MemValid),
    .I_MemVector       (I_MemVector),
    .I_MemRegIdx       (I_MemRegIdx),
    .I_MemData         (I_MemData),
    .O_MemReady        (O_MemReady),
    .I_AluValid        (I_AluValid),
    .I_AluVector       (I_AluVector),
    .I_AluRegIdx       (I_AluRegIdx),
    .I_AluData         (I_AluData),
    .O_AluReady        (O_AluReady),
    .O_WriteBackEnable (O_WriteBackEnable),
    .O_VWriteBackEnable(O_VWriteBackEnable),
    .O_WriteBackRegIdx (O_WriteBackRegIdx),
    .O_WriteBackData   (O_WriteBackData),
    .O_VWriteBackData  (O_VWriteBackData),
    .O_Empty           (O_Empty)
`ifdef WB_COND_CODE_EN
    ,
    .O_CondCode        (O_CondCode)
`endif
  );

  initial I_CLOCK = 1'b0;
  always #5 I_CLOCK = ~I_CLOCK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge I_CLOCK);
    #1;
  endtask

  task automatic idle_inputs();
    I_MemValid  = 1'b0;
    I_MemVector = 1'b0;
    I_MemRegIdx = '0;
    I_MemData   = '0;
    I_AluValid  = 1'b0;
    I_AluVector = 1'b0;
    I_AluRegIdx = '0;
    I_AluData   = '0;
  endtask

  // Items not yet written back, oldest first: {vector, idx, data}.
  logic [70:0] pend[$];
  logic [70:0] item;
  logic        mem_ok;
  logic        alu_ok;

  initial begin
    I_RESET = 1'b1;
    idle_inputs();
    step();
    step();
    I_RESET = 1'b0;
    step();

    // Idle after reset
    check("rst_wb_en", O_WriteBackEnable, 1'b0);
    check("rst_vwb_en", O_VWriteBackEnable, 1'b0);
    check("rst_idx", O_WriteBackRegIdx, 6'd0);
    check("rst_data", O_WriteBackData, 16'h0000);
    check("rst_vdata", O_VWriteBackData, 64'h0);
    check("rst_empty", O_Empty, 1'b1);
    check("rst_mem_rdy", O_MemReady, 1'b1);
    check("rst_alu_rdy", O_AluReady, 1'b1);
`ifdef WB_COND_CODE_EN
    check("rst_cc", O_CondCode, 3'b000);
`endif

    // Single ALU scalar: visible in the cycle after acceptance
    I_AluValid  = 1'b1;
    I_AluVector = 1'b0;
    I_AluRegIdx = 6'd3;
    I_AluData   = 64'h0005;
    step();
    idle_inputs();
    check("alu1_wb_en", O_WriteBackEnable, 1'b1);
    check("alu1_vwb_en", O_VWriteBackEnable, 1'b0);
    check("alu1_idx", O_WriteBackRegIdx, 6'd3);
    check("alu1_data", O_WriteBackData, 16'h0005);
    check("alu1_empty", O_Empty, 1'b0);
`ifdef WB_COND_CODE_EN
    check("alu1_cc", O_CondCode, 3'b001);
`endif
    step();
    check("alu1_done_en", O_WriteBackEnable, 1'b0);
    check("alu1_done_empty", O_Empty, 1'b1);

    // Memory scalar and ALU vector together: memory first
    I_MemValid  = 1'b1;
    I_MemVector = 1'b0;
    I_MemRegIdx = 6'd2;
    I_MemData   = 64'h8000;
    I_AluValid  = 1'b1;
    I_AluVector = 1'b1;
    I_AluRegIdx = 6'd5;
    I_AluData   = 64'h0001_0002_0003_0004;
    step();
    idle_inputs();
    check("pair_s_en", O_WriteBackEnable, 1'b1);
    check("pair_s_ven", O_VWriteBackEnable, 1'b0);
    check("pair_s_idx", O_WriteBackRegIdx, 6'd2);
    check("pair_s_data", O_WriteBackData, 16'h8000);
`ifdef WB_COND_CODE_EN
    check("pair_s_cc", O_CondCode, 3'b100);
`endif
    step();
    check("pair_v_en", O_WriteBackEnable, 1'b0);
    check("pair_v_ven", O_VWriteBackEnable, 1'b1);
    check("pair_v_idx", O_WriteBackRegIdx, 6'd5);
    check("pair_v_vdata", O_VWriteBackData, 64'h0001_0002_0003_0004);
    check("pair_v_hold", O_WriteBackData, 16'h8000);
`ifdef WB_COND_CODE_EN
    check("pair_v_cc", O_CondCode, 3'b100);
`endif
    step();
    check("pair_end_ven", O_VWriteBackEnable, 1'b0);
    check("pair_end_vhold", O_VWriteBackData, 64'h0001_0002_0003_0004);
    check("pair_end_empty", O_Empty, 1'b1);

    // Same destination from both paths: ALU value lands last
    I_MemValid  = 1'b1;
    I_MemRegIdx = 6'd1;
    I_MemData   = 64'h0000;
    I_AluValid  = 1'b1;
    I_AluRegIdx = 6'd1;
    I_AluData   = 64'h0007;
    step();
    idle_inputs();
    check("same_1_en", O_WriteBackEnable, 1'b1);
    check("same_1_idx", O_WriteBackRegIdx, 6'd1);
    check("same_1_data", O_WriteBackData, 16'h0000);
`ifdef WB_COND_CODE_EN
    check("same_1_cc", O_CondCode, 3'b010);
`endif
    step();
    check("same_2_en", O_WriteBackEnable, 1'b1);
    check("same_2_idx", O_WriteBackRegIdx, 6'd1);
    check("same_2_data", O_WriteBackData, 16'h0007);
`ifdef WB_COND_CODE_EN
    check("same_2_cc", O_CondCode, 3'b001);
`endif
    step();
    check("same_end_empty", O_Empty, 1'b1);

    // Both paths valid every cycle; the model queue predicts readiness and write order
    for (int i = 0; i < 8; i++) begin
      mem_ok = (pend.size() < DEPTH);
      alu_ok = (pend.size() < DEPTH - 1);
      check("burst_mem_rdy", O_MemReady, mem_ok);
      check("burst_alu_rdy", O_AluReady, alu_ok);
      I_MemValid  = 1'b1;
      I_MemVector = 1'b0;
      I_MemRegIdx = 6'(i);
      I_MemData   = 64'(32'h1000 + i);
      I_AluValid  = 1'b1;
      I_AluVector = 1'b0;
      I_AluRegIdx = 6'(16 + i);
      I_AluData   = 64'(32'h2000 + i);
      if (mem_ok) pend.push_back({1'b0, 6'(i), 64'(32'h1000 + i)});
      if (alu_ok) pend.push_back({1'b0, 6'(16 + i), 64'(32'h2000 + i)});
      step();
      item = pend.pop_front();
      check("burst_en", O_WriteBackEnable, 1'b1);
      check("burst_idx", O_WriteBackRegIdx, item[69:64]);
      check("burst_data", O_WriteBackData, item[15:0]);
    end
    idle_inputs();
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (pend.size() != 0) begin
        step();
        item = pend.pop_front();
        check("drain_en", O_WriteBackEnable, 1'b1);
        check("drain_idx", O_WriteBackRegIdx, item[69:64]);
        check("drain_data", O_WriteBackData, item[15:0]);
      end
    end
    step();
    check("drain_end_en", O_WriteBackEnable, 1'b0);
    check("drain_end_empty", O_Empty, 1'b1);

    // Fill three entries, then reset with inputs still presented
    for (int i = 0; i < 3; i++) begin
      I_MemValid  = 1'b1;
      I_MemRegIdx = 6'(40 + i);
      I_MemData   = 64'(32'h3000 + i);
      I_AluValid  = 1'b1;
      I_AluRegIdx = 6'(50 + i);
      I_AluData   = 64'(32'h4000 + i);
      step();
    end
    check("fill_alu_rdy", O_AluReady, 1'b0);
    I_RESET = 1'b1;
    step();
    I_RESET = 1'b0;
    idle_inputs();
    check("mrst_en", O_WriteBackEnable, 1'b0);
    check("mrst_ven", O_VWriteBackEnable, 1'b0);
    check("mrst_idx", O_WriteBackRegIdx, 6'd0);
    check("mrst_data", O_WriteBackData, 16'h0000);
    check("mrst_empty", O_Empty, 1'b1);
    check("mrst_mem_rdy", O_MemReady, 1'b1);
    check("mrst_alu_rdy", O_AluReady, 1'b1);
`ifdef WB_COND_CODE_EN
    check("mrst_cc", O_CondCode, 3'b000);
`endif
    for (int i = 0; i < 6; i++) begin
      step();
      check("post_rst_en", O_WriteBackEnable, 1'b0);
      check("post_rst_empty", O_Empty, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Final pipeline stage of the GPU core: accepts completed scalar and vector results from the execute (ALU) and memory (LDW) paths, orders them, and drives the register-file write port consumed by the decode stage. It retires at most one write per cycle. Results arriving together are held in a small in-order queue so that no result is lost. The write port it drives is what releases the decode stage's register valid bits.

## Interface
- `REG_WIDTH`, 16: scalar register width.
- `VREG_WIDTH`, 64: vector register width.
- `DEPTH`, 4: pending-result queue entries; power of two, ≥2.
- `I_CLOCK`  in  1  sole clock; all state updates on posedge.
- `I_RESET`  in  1  reset; one clock, synchronous, active-high.
- `I_MemValid`  in  1  memory-path result present.
- `I_MemVector`  in  1  1 = vector result, 0 = scalar.
- `I_MemRegIdx`  in  6  destination register index.
- `I_MemData`  in  VREG_WIDTH  result; scalar uses [REG_WIDTH-1:0].
- `O_MemReady`  out  1  memory-path result accepted this cycle if valid.
- `I_AluValid`, `I_AluVector`, `I_AluRegIdx`, `I_AluData`  in  1/1/6/VREG_WIDTH  ALU-path result, same meanings as memory path.
- `O_AluReady`  out  1  ALU-path result accepted this cycle if valid.
- `O_WriteBackEnable`  out  1  scalar write this cycle.
- `O_VWriteBackEnable`  out  1  vector write this cycle.
- `O_WriteBackRegIdx`  out  6  destination index (shared by scalar and vector).
- `O_WriteBackData`  out  REG_WIDTH  scalar write data.
- `O_VWriteBackData`  out  VREG_WIDTH  vector write data.
- `O_CondCode`  out  3  N/Z/P condition code; present only with `WB_COND_CODE_EN`.
- `O_Empty`  out  1  queue empty and no write on the port this cycle.

## Operation
- Queue entry: {vector, idx[5:0], data[VREG_WIDTH-1:0]}, circular buffer with head, tail and count (0..DEPTH).
- Ready signals are combinational from the registered count only, never from the valid inputs:
  - `O_MemReady` = count < DEPTH.
  - `O_AluReady` = count < DEPTH-1.
- Acceptance is a handshake: valid && ready. Per cycle, at most one memory result and one ALU result are accepted.
- Ordering:
  - The memory result is older in program order.
  - It is enqueued (or bypassed) before a same-cycle ALU result.
  - Queue order is strict FIFO.
- Each cycle the output register loads the oldest available item: queue head if count > 0, else the same-cycle memory arrival, else the same-cycle ALU arrival. If none exists, both enables are 0.
- The write port has no back-pressure; the decode stage always consumes it.
- Scalar item:
  - `O_WriteBackEnable`=1, `O_VWriteBackEnable`=0.
  - `O_WriteBackData` = data[REG_WIDTH-1:0].
  - `O_VWriteBackData` holds its previous value.
- Vector item is the mirror case: only `O_VWriteBackEnable`=1 and `O_VWriteBackData` = data; `O_WriteBackData` holds.
- count_next = count + accepted − popped; pointers wrap modulo DEPTH.
- Same destination index from both paths in one cycle: both writes are issued, memory first, so the ALU value lands last.

## Timing
- Latency: accepted at edge N with queue empty → on write port during cycle N+1 (one registered stage).
- Both paths accepted at N, queue empty: memory result in cycle N+1, ALU result in N+2.
- Sustained throughput: one write per cycle.
- Full: count==DEPTH deasserts `O_MemReady`; count ≥ DEPTH-1 deasserts `O_AluReady`.
- Enqueue and pop in the same cycle at full: the pop frees a slot only from the next cycle, because ready uses registered count.
- Reset, at the next posedge while `I_RESET`=1, including mid-burst:
  - count, head and tail = 0; queued entries are discarded.
  - Both enables = 0, `O_WriteBackRegIdx`=0, both data outputs = 0, `O_CondCode`=0.
  - `O_Empty`=1; ready outputs are 1 once count=0.
- Inputs presented during reset are not accepted.

## Configuration
- `WB_COND_CODE_EN` defined:
  - A 3-bit register updates on each cycle the write port carries a scalar write.
  - Value is 3'b100 if data[REG_WIDTH-1]=1, 3'b010 if data==0, else 3'b001.
  - It updates in the same cycle the write appears; vector writes do not change it; reset value is 0.
- Undefined: the register and `O_CondCode` port are absent, and the rest of the behaviour is unchanged.

## Test plan
- Reset, then idle: all outputs 0, `O_Empty`=1, `O_MemReady`=`O_AluReady`=1.
- Single ALU scalar, idx 3, data 0x0005, at edge N → cycle N+1: `O_WriteBackEnable`=1, idx 3, data 0x0005; cycle N+2: enable 0; CC=3'b001 (with macro).
- Same cycle, memory scalar idx 2 = 0x8000 and ALU vector idx 5 = 0x0001_0002_0003_0004 → N+1: scalar write idx 2, CC=3'b100; N+2: `O_VWriteBackEnable`=1 idx 5, CC unchanged.
- Both paths valid every cycle, DEPTH=4 → `O_AluReady` falls when count=3 and `O_MemReady` falls when count=4. Every accepted result appears exactly once, in order memory-before-ALU per cycle, one per cycle.
- Same destination idx 1 from both paths, memory=0x0000 and ALU=0x0007 → writes to idx 1 in order 0x0000 then 0x0007; CC 3'b010 then 3'b001.
- Queue holding 3 entries, `I_RESET`=1 for one cycle → next cycle enables 0, `O_Empty`=1; no queued entry is ever emitted afterwards.
